// File: rtl/ccc_lock_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ccc_lock_reset_ctrl
//  Description : Qualifies the raw CCC PLL LOCK signal and sequences the
//                downstream SCCB reset. LOCK is brought into the CLK domain
//                through a two-flop synchronizer (lock_s). Once lock_s has
//                been high for STABLE_CYCLES consecutive cycles the block
//                enters RUN. In RUN it releases SYS_RESET, raises READY and
//                emits a one-cycle SCCB_TICK every TICK_DIV cycles. A loss of
//                lock in RUN re-asserts SYS_RESET for HOLD_CYCLES cycles,
//                sets the sticky LOCK_LOST flag and bumps the saturating
//                LOSS_COUNT.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK          in   1  single clock (CCC GL0 global net)
//    RESET        in   1  synchronous, active-high reset
//    LOCK         in   1  raw PLL lock, asynchronous to CLK
//    CLEAR_STICKY in   1  one-cycle request to clear LOCK_LOST
//    SYS_RESET    out  1  synchronous active-high reset for SCCB logic
//    READY        out  1  high only while in RUN
//    LOCK_LOST    out  1  sticky lock-loss flag
//    LOSS_COUNT   out  8  saturating count of lock losses from RUN
//    SCCB_TICK    out  1  one-cycle enable every TICK_DIV cycles in RUN
//  Parameters (all must be >= 1)
//    STABLE_CYCLES  consecutive lock_s-high cycles required before RUN
//    HOLD_CYCLES    cycles spent in LOST before re-qualification starts
//    TICK_DIV       SCCB_TICK period in CLK cycles
// ============================================================================
module ccc_lock_reset_ctrl #(
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int TICK_DIV      = 125
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LOCK,
    input  logic       CLEAR_STICKY,
    output logic       SYS_RESET,
    output logic       READY,
    output logic       LOCK_LOST,
    output logic [7:0] LOSS_COUNT,
    output logic       SCCB_TICK
);

    localparam int c_stab_w = $clog2(STABLE_CYCLES + 1);
    localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);
    localparam int c_tick_w = $clog2(TICK_DIV + 1);

    localparam logic [c_stab_w-1:0] c_stab_target = c_stab_w'(STABLE_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_last   = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_tick_w-1:0] c_tick_last   = c_tick_w'(TICK_DIV - 1);
    localparam logic [7:0]          c_loss_max    = 8'hFF;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_RUN       = 2'd2,
        ST_LOST      = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic                sync1_q,     sync1_d;
    logic                lock_s_q,    lock_s_d;
    state_t              state_q,     state_d;
    logic [c_stab_w-1:0] stab_cnt_q,  stab_cnt_d;
    logic [c_hold_w-1:0] hold_cnt_q,  hold_cnt_d;
    logic [c_tick_w-1:0] tick_cnt_q,  tick_cnt_d;
    logic                sys_reset_q, sys_reset_d;
    logic                ready_q,     ready_d;
    logic                lock_lost_q, lock_lost_d;
    logic [7:0]          loss_cnt_q,  loss_cnt_d;
    logic                sccb_tick_q, sccb_tick_d;
    logic                loss_event;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= ST_WAIT_LOCK;
            stab_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            tick_cnt_q  <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
            sccb_tick_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            lock_s_q    <= lock_s_d;
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            loss_cnt_q  <= loss_cnt_d;
            sccb_tick_q <= sccb_tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d    = LOCK;
        lock_s_d   = sync1_q;
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        hold_cnt_d = hold_cnt_q;
        loss_event = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                stab_cnt_d = '0;
                hold_cnt_d = '0;
                if (lock_s_q) begin
                    // The cycle that first sees lock_s high counts as one.
                    state_d    = ST_STABILIZE;
                    stab_cnt_d = c_stab_w'(1);
                end
            end
            ST_STABILIZE: begin
                if (!lock_s_q) begin
                    state_d    = ST_WAIT_LOCK;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == c_stab_target) begin
                    state_d    = ST_RUN;
                    stab_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + c_stab_w'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d    = ST_LOST;
                    hold_cnt_d = '0;
                    loss_event = 1'b1;
                end
            end
            ST_LOST: begin
                // Lock is ignored here: the hold time is served in full.
                if (hold_cnt_q == c_hold_last) begin
                    state_d    = ST_WAIT_LOCK;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + c_hold_w'(1);
                end
            end
            default: begin
                state_d    = ST_WAIT_LOCK;
                stab_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase

        // Tick counter restarts at 0 on the first RUN cycle, so the first
        // pulse lands on the TICK_DIV-th cycle of RUN.
        tick_cnt_d = '0;
        if (state_d == ST_RUN && state_q == ST_RUN) begin
            tick_cnt_d = (tick_cnt_q == c_tick_last) ? '0 : tick_cnt_q + c_tick_w'(1);
        end

        // Outputs are registered from the next state so they change in
        // lockstep with the state register.
        sys_reset_d = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
        sccb_tick_d = (state_d == ST_RUN) && (tick_cnt_d == c_tick_last);

        // A loss event beats a coincident clear request.
        if (loss_event) begin
            lock_lost_d = 1'b1;
        end else if (CLEAR_STICKY) begin
            lock_lost_d = 1'b0;
        end else begin
            lock_lost_d = lock_lost_q;
        end

        loss_cnt_d = loss_cnt_q;
        if (loss_event && loss_cnt_q != c_loss_max) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    assign SYS_RESET  = sys_reset_q;
    assign READY      = ready_q;
    assign LOCK_LOST  = lock_lost_q;
    assign LOSS_COUNT = loss_cnt_q;
    assign SCCB_TICK  = sccb_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_ccc_lock_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccc_lock_reset_ctrl
//  Description : Self-checking bench for ccc_lock_reset_ctrl with
//                STABLE_CYCLES=8, HOLD_CYCLES=4, TICK_DIV=5. A table of
//                hand-derived vectors, directed multi-cycle sequences and a
//                randomized phase, all cross-checked every cycle against a
//                behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccc_lock_reset_ctrl;

    localparam int S = 8;
    localparam int H = 4;
    localparam int T = 5;

    localparam int M_WAIT = 0;
    localparam int M_STAB = 1;
    localparam int M_RUN  = 2;
    localparam int M_LOST = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       clr;
    logic       sys_reset;
    logic       ready;
    logic       lock_lost;
    logic [7:0] loss_count;
    logic       tick;

    always #5 clk = ~clk;

    ccc_lock_reset_ctrl #(
        .STABLE_CYCLES (S),
        .HOLD_CYCLES   (H),
        .TICK_DIV      (T)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .LOCK         (lock),
        .CLEAR_STICKY (clr),
        .SYS_RESET    (sys_reset),
        .READY        (ready),
        .LOCK_LOST    (lock_lost),
        .LOSS_COUNT   (loss_count),
        .SCCB_TICK    (tick)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int m_mode    = M_WAIT;
    int m_stab    = 0;
    int m_left    = 0;
    int m_run_len = 0;
    int m_count   = 0;
    bit m_lost    = 1'b0;
    bit m_hist [2] = '{1'b0, 1'b0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        bit ls;
        bit ev;
        if (rst) begin
            m_hist    = '{1'b0, 1'b0};
            m_mode    = M_WAIT;
            m_stab    = 0;
            m_left    = 0;
            m_run_len = 0;
            m_lost    = 1'b0;
            m_count   = 0;
        end else begin
            ls = m_hist[1];
            ev = 1'b0;
            case (m_mode)
                M_WAIT: begin
                    if (ls) begin m_mode = M_STAB; m_stab = 1; end
                end
                M_STAB: begin
                    if (!ls) begin m_mode = M_WAIT; m_stab = 0; end
                    else if (m_stab == S) begin m_mode = M_RUN; m_run_len = 0; end
                    else m_stab++;
                end
                M_RUN: begin
                    if (!ls) begin m_mode = M_LOST; m_left = H; ev = 1'b1; end
                    else m_run_len++;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_WAIT;
                end
            endcase
            if (ev) begin
                m_lost = 1'b1;
                if (m_count < 255) m_count++;
            end else if (clr) begin
                m_lost = 1'b0;
            end
            m_hist[1] = m_hist[0];
            m_hist[0] = lock;
        end
    endtask

    task automatic check_model();
        bit run;
        run = (m_mode == M_RUN);
        chk("model.sys_reset",  sys_reset,  !run);
        chk("model.ready",      ready,      run);
        chk("model.lock_lost",  lock_lost,  m_lost);
        chk("model.loss_count", loss_count, m_count);
        chk("model.sccb_tick",  tick,       run && ((m_run_len % T) == T - 1));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_model();
    endtask

    // Step until the chosen output reaches val, or give up after bound cycles.
    task automatic wait_for(input int which, input logic val, input int bound, input string nm);
        int n;
        logic cur;
        n = 0;
        cur = (which == 0) ? sys_reset : ready;
        while (cur !== val && n < bound) begin
            step();
            n++;
            cur = (which == 0) ? sys_reset : ready;
        end
        chk(nm, cur, val);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit rst;
        bit lock;
        bit clr;
        int cycles;
        bit e_sys;
        bit e_ready;
        bit e_lost;
        int e_cnt;
        bit e_tick;
    } vec_t;

    vec_t vt [13];

    initial begin
        int n;
        rst  = 1'b1;
        lock = 1'b0;
        clr  = 1'b0;

        // Cycle numbers count posedges after RESET release (first = 1).
        //        rst   lock  clr   cyc sys   rdy   lost  cnt tick
        vt[0]  = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0}; // reset
        vt[1]  = '{1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0, 0, 1'b0}; // c10 still qualifying
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0, 1'b0}; // c11 RUN
        vt[3]  = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b0, 0, 1'b0}; // c14
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0, 1'b1}; // c15 tick
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0, 1'b0}; // c16
        vt[6]  = '{1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 0, 1'b1}; // c20 tick
        vt[7]  = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 0, 1'b0}; // c22 drop in flight
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1, 1'b0}; // c23 LOST
        vt[9]  = '{1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1, 1'b0}; // c24 clear
        vt[10] = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1, 1'b0}; // c34 WAIT
        vt[11] = '{1'b0, 1'b1, 1'b0, 11, 1'b0, 1'b1, 1'b0, 1, 1'b0}; // c45 RUN again
        vt[12] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0, 1'b0}; // reset in RUN

        for (int i = 0; i < 13; i++) begin
            rst  = vt[i].rst;
            lock = vt[i].lock;
            clr  = vt[i].clr;
            repeat (vt[i].cycles) step();
            chk($sformatf("vec%0d.sys_reset", i),  sys_reset,  vt[i].e_sys);
            chk($sformatf("vec%0d.ready", i),      ready,      vt[i].e_ready);
            chk($sformatf("vec%0d.lock_lost", i),  lock_lost,  vt[i].e_lost);
            chk($sformatf("vec%0d.loss_count", i), loss_count, vt[i].e_cnt);
            chk($sformatf("vec%0d.sccb_tick", i),  tick,       vt[i].e_tick);
        end
        clr = 1'b0;

        // Glitch during STABILIZE restarts qualification.
        rst = 1'b1; lock = 1'b0; step();
        rst = 1'b0; lock = 1'b1;
        repeat (7) step();
        lock = 1'b0;
        repeat (3) step();
        lock = 1'b1;
        n = 0;
        while (sys_reset === 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("requal.latency", n, 11);
        chk("requal.ready", ready, 1'b1);
        chk("requal.lock_lost", lock_lost, 1'b0);

        // Clear coincident with RUN->LOST loses; a later clear wins.
        lock = 1'b0;
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_same.lock_lost", lock_lost, 1'b1);
        chk("clr_same.sys_reset", sys_reset, 1'b1);
        chk("clr_same.loss_count", loss_count, 1);
        repeat (2) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_alone.lock_lost", lock_lost, 1'b0);
        chk("clr_alone.loss_count", loss_count, 1);
        lock = 1'b1;
        wait_for(1, 1'b1, 40, "relock.ready");

        // Loss counter saturation.
        for (int i = 0; i < 260; i++) begin
            lock = 1'b0;
            wait_for(0, 1'b1, 10, "sat.loss_seen");
            lock = 1'b1;
            wait_for(1, 1'b1, 40, "sat.relock");
        end
        chk("sat.loss_count", loss_count, 255);
        chk("sat.lock_lost", lock_lost, 1'b1);

        // Reset in the middle of RUN.
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_run.sys_reset", sys_reset, 1'b1);
        chk("rst_run.ready", ready, 1'b0);
        chk("rst_run.lock_lost", lock_lost, 1'b0);
        chk("rst_run.loss_count", loss_count, 0);
        chk("rst_run.sccb_tick", tick, 1'b0);

        // Randomized phase, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) lock = ~lock;
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
